// File: rtl/pipeline_trace_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_pkg : shared state enum and state_o encoding for the trace buffer
// Rev 1.0
// ---------------------------------------------------------------------------
package trace_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ARMED = 2'd1;
    localparam logic [1:0] STATE_POST  = 2'd2;
    localparam logic [1:0] STATE_READ  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE,
        ST_ARMED = STATE_ARMED,
        ST_POST  = STATE_POST,
        ST_READ  = STATE_READ
    } trace_state_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_trace_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_trace_buffer_if : probe capture and trace readout signals
// Rev 1.0
// ---------------------------------------------------------------------------
interface pipeline_trace_buffer_if #(
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 4,
    parameter int DEPTH   = 32,
    parameter int STAMP_W = 16
);
    logic                       arm;
    logic                       probe_valid;
    logic [NUM_CH*DATA_W-1:0]   probe_data;
    logic                       trig;
    logic                       rd_valid;
    logic                       rd_ready;
    logic [NUM_CH*DATA_W-1:0]   rd_data;
    logic [STAMP_W-1:0]         rd_stamp;
    logic                       rd_last;
    logic [1:0]                 state_o;
    logic [$clog2(DEPTH):0]     count_o;

    modport master (
        output arm, probe_valid, probe_data, trig, rd_ready,
        input  rd_valid, rd_data, rd_stamp, rd_last, state_o, count_o
    );

    modport slave (
        input  arm, probe_valid, probe_data, trig, rd_ready,
        output rd_valid, rd_data, rd_stamp, rd_last, state_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_ram : DEPTH x WIDTH storage, one synchronous write, async read
// Rev 1.0
// ---------------------------------------------------------------------------
module trace_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 80
) (
    input  wire logic                     clk,
    input  wire logic                     we,
    input  wire logic [$clog2(DEPTH)-1:0] waddr,
    input  wire logic [WIDTH-1:0]         wdata,
    input  wire logic [$clog2(DEPTH)-1:0] raddr,
    output logic      [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule
`default_nettype wire

// File: rtl/pipeline_trace_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_trace_buffer : triggered ring-buffer capture of pipeline probes
// Rev 1.0
// ---------------------------------------------------------------------------
module pipeline_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 32,
    parameter int POST_TRIG = 8,
    parameter int STAMP_W   = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    pipeline_trace_buffer_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    localparam int PW  = NUM_CH * DATA_W;
    localparam int EW  = PW + STAMP_W;
    localparam logic [AW:0] FULL      = AW1'(DEPTH);
    localparam logic [AW:0] ONE       = AW1'(1);
    localparam logic [AW:0] LAST_POST = AW1'(POST_TRIG - 1);

    if (POST_TRIG >= DEPTH) begin : g_bad_post_trig
        $error("pipeline_trace_buffer: POST_TRIG must be less than DEPTH");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pipeline_trace_buffer: DEPTH must be a power of two >= 4");
    end

    trace_state_e       state, state_nx;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count, post_cnt;
    logic [STAMP_W-1:0] stamp;
    logic               rd_valid;
    logic               wr_en;
    logic               xfer;
    logic [EW-1:0]      rd_word;

    assign wr_en = bus.probe_valid && (state == ST_ARMED || state == ST_POST);
    assign xfer  = rd_valid && bus.rd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (bus.arm) state_nx = ST_ARMED;
            ST_ARMED: if (bus.trig) state_nx = (POST_TRIG == 0) ? ST_READ : ST_POST;
            ST_POST:  if (bus.probe_valid && post_cnt == LAST_POST) state_nx = ST_READ;
            ST_READ:  if ((!rd_valid && count == '0) || (xfer && count == ONE)) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // rd_valid low while in READ marks its first cycle, where the oldest entry is located.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stamp    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
            rd_valid <= 1'b0;
        end else begin
            stamp <= stamp + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (bus.arm) begin
                        wr_ptr <= '0;
                        count  <= '0;
                    end
                end
                ST_ARMED, ST_POST: begin
                    if (bus.probe_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (count != FULL) begin
                            count <= count + 1'b1;
                        end
                    end
                    if (state == ST_ARMED) begin
                        post_cnt <= '0;
                    end else if (bus.probe_valid) begin
                        post_cnt <= post_cnt + 1'b1;
                    end
                end
                ST_READ: begin
                    if (!rd_valid) begin
                        if (count != '0) begin
                            rd_ptr   <= wr_ptr - count[AW-1:0];
                            rd_valid <= 1'b1;
                        end
                    end else if (bus.rd_ready) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        count  <= count - 1'b1;
                        if (count == ONE) begin
                            rd_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({bus.probe_data, stamp}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_valid ? rd_word[EW-1:STAMP_W] : '0;
    assign bus.rd_stamp = rd_valid ? rd_word[STAMP_W-1:0] : '0;
    assign bus.rd_last  = rd_valid && (count == ONE);
    assign bus.state_o  = state;
    assign bus.count_o  = count;
endmodule
`default_nettype wire

// File: doc/pipeline_trace_buffer.md
PIPELINE_TRACE_BUFFER -- requirements
Module: pipeline_trace_buffer

Interface
REQ-001 Parameter DATA_W, 16, width of one probe channel.
REQ-002 Parameter NUM_CH, 4, number of probe channels captured per sample (e.g. PC, instruction, ALU result, WB data).
REQ-003 Parameter DEPTH, 32, trace entries; power of two, >= 4.
REQ-004 Parameter POST_TRIG, 8, samples recorded after the trigger sample; elaboration error unless POST_TRIG < DEPTH.
REQ-005 Parameter STAMP_W, 16, cycle-stamp width.
REQ-006 clk  in  1  single clock; all logic is rising-edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 arm  in  1  one-cycle pulse that starts a capture.
REQ-009 probe_valid  in  1  probe_data is a valid sample this cycle.
REQ-010 probe_data  in  NUM_CH*DATA_W  channel k in bits [k*DATA_W +: DATA_W].
REQ-011 trig  in  1  trigger, e.g. halt or a mismatch flag.
REQ-012 rd_valid  out  1  rd_data/rd_stamp hold a trace entry.
REQ-013 rd_ready  in  1  consumer accepts the entry.
REQ-014 rd_data  out  NUM_CH*DATA_W  captured probe word.
REQ-015 rd_stamp  out  STAMP_W  cycle stamp of the entry.
REQ-016 rd_last  out  1  entry is the final one of the capture.
REQ-017 state_o  out  2  IDLE=0, ARMED=1, POST=2, READ=3.
REQ-018 count_o  out  clog2(DEPTH)+1  entries currently stored.

Function
REQ-019 A free-running STAMP_W-bit counter SHALL increment every cycle out of reset and wrap modulo 2^STAMP_W.
REQ-020 Each stored entry SHALL be {probe_data, stamp of its capture cycle}.
REQ-021 IDLE: arm SHALL clear the write pointer and count and move to ARMED next cycle; all other inputs are ignored.
REQ-022 ARMED: each cycle with probe_valid SHALL write one entry at the write pointer, which advances modulo DEPTH; count saturates at DEPTH, and the oldest entry is overwritten when full.
REQ-023 ARMED: trig SHALL move to POST; the trigger-cycle sample is recorded if probe_valid and is not counted toward POST_TRIG.
REQ-024 POST: each probe_valid sample SHALL be recorded; after POST_TRIG recorded samples, move to READ; trig is ignored in POST.
REQ-025 POST_TRIG=0 SHALL go from ARMED directly to READ on the trigger cycle.
REQ-026 READ: the read pointer SHALL start at the oldest entry (write pointer minus count, modulo DEPTH); rd_valid asserts the cycle after READ is entered.
REQ-027 rd_data/rd_stamp/rd_last SHALL stay stable while rd_valid && !rd_ready.
REQ-028 A transfer (rd_valid && rd_ready) SHALL advance the read pointer and decrement count; rd_last marks the newest entry; on its transfer the block returns to IDLE.
REQ-029 READ with count 0 (trigger before any valid sample, POST_TRIG=0) SHALL return to IDLE without asserting rd_valid.
REQ-030 arm SHALL be ignored outside IDLE; probe_valid and trig SHALL be ignored in IDLE and READ.
REQ-031 No sample SHALL be written in READ; capture order SHALL be preserved across wrap-around.

Reset
REQ-032 reset SHALL force state IDLE, pointers and count 0, stamp counter 0, and rd_valid, rd_last, state_o and count_o to 0; rd_data and rd_stamp reset to 0.
REQ-033 reset mid-capture or mid-readout SHALL discard all entries; trace storage contents need not be cleared.

Structure
REQ-034 A shared package trace_pkg SHALL hold the state enum (IDLE/ARMED/POST/READ) and the state_o encoding constants.
REQ-035 Storage SHALL be one sub-module trace_ram: DEPTH x (NUM_CH*DATA_W+STAMP_W), one write port and one asynchronous read port; control logic stays in pipeline_trace_buffer.

Verification (DEPTH=8, POST_TRIG=2, NUM_CH=2, DATA_W=16, STAMP_W=16 unless stated)
REQ-036 Arm, 20 valid samples with data=index, trig on index 10 -> 8 entries, indices 5..12, rd_last on 12.
REQ-037 Arm, trig on the 3rd valid sample -> 5 entries, indices 1..5, count_o 5 before readout.
REQ-038 Readout with rd_ready low for 3 cycles mid-stream -> rd_data/rd_stamp unchanged across the stall; no entry lost or duplicated.
REQ-039 probe_valid on alternate cycles -> rd_stamp values step by 2; with STAMP_W=4, stamps wrap from 15 to 0 in order.
REQ-040 reset asserted during POST -> state_o 0, count_o 0, rd_valid 0 next cycle; a new arm works normally.
REQ-041 POST_TRIG=0, trig in the first ARMED cycle with probe_valid low -> no rd_valid, back to IDLE.
